// File: rtl/ex_mul_if.sv
// Handshake bundle between the ID/EX operand side and the EX/MEM result side
// of the iterative multiplier.
interface ex_mul_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            busy;

    modport master (
        output in_valid, funct3, rs1_val, rs2_val, rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, busy
    );

    modport slave (
        input  in_valid, funct3, rs1_val, rs2_val, rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, busy
    );
endinterface

// File: rtl/ex_mul_unit.sv
// Iterative shift-add RV32M multiplier, one multiplier bit per cycle.
// Define MUL_HIGH_EN for MULH/MULHSU/MULHU; otherwise every op is an unsigned low-half MUL.
module ex_mul_unit #(
    parameter int XLEN = 32
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     flush,
    ex_mul_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
`ifdef MUL_HIGH_EN
    localparam int ACCW = 2 * XLEN;
`else
    localparam int ACCW = XLEN;
`endif
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_tag;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_out_rd;
    logic            r_valid;
    logic            r_busy;

    logic            w_in_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic [ACCW-1:0] w_acc_next;
    logic [XLEN-1:0] w_res;

    assign w_in_ready = (r_state == S_IDLE) && !reset && !flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {ACCW{1'b0}});

`ifdef MUL_HIGH_EN
    localparam logic [XLEN-1:0] ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [ACCW-1:0] ONE_A = {{(ACCW-1){1'b0}}, 1'b1};

    logic            r_neg;
    logic [1:0]      r_op;
    logic            w_s1;
    logic            w_s2;
    logic [ACCW-1:0] w_prod;
    logic            w_unused;

    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign w_s1   = ((bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10)) && bus.rs1_val[XLEN-1];
    assign w_s2   = (bus.funct3[1:0] == 2'b01) && bus.rs2_val[XLEN-1];
    assign w_mag1 = w_s1 ? (~bus.rs1_val + ONE_X) : bus.rs1_val;
    assign w_mag2 = w_s2 ? (~bus.rs2_val + ONE_X) : bus.rs2_val;
    assign w_prod = r_neg ? (~w_acc_next + ONE_A) : w_acc_next;
    assign w_res  = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[ACCW-1:XLEN];
    assign w_unused = bus.funct3[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_neg <= 1'b0;
            r_op  <= 2'b00;
        end else if (w_accept) begin
            r_neg <= w_s1 ^ w_s2;
            r_op  <= bus.funct3[1:0];
        end
    end
`else
    logic w_unused;

    assign w_mag1   = bus.rs1_val;
    assign w_mag2   = bus.rs2_val;
    assign w_res    = w_acc_next[XLEN-1:0];
    assign w_unused = ^bus.funct3;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_out_rd <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_state  <= S_RUN;
                        r_acc    <= '0;
                        r_mcand  <= ACCW'(w_mag1);
                        r_mplier <= w_mag2;
                        r_cnt    <= CW'(XLEN - 1);
                        r_tag    <= bus.rd;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_ONE;
                    // Last partial product is folded in on the same edge the result is latched.
                    if (r_cnt == '0) begin
                        r_state  <= S_DONE;
                        r_result <= w_res;
                        r_out_rd <= r_tag;
                        r_valid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_rd     = r_out_rd;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: driver pushes model results on accept,
// monitor pops and compares on every output handshake.
module tb_ex_mul_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    ex_mul_if #(.XLEN(32)) bus ();

    ex_mul_unit #(.XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    bit   rand_bp = 1'b0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on widened operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] sa, sb_, p;
`ifdef MUL_HIGH_EN
        sa = (op == 2'd1 || op == 2'd2) ? $signed({{34{a[31]}}, a}) : $signed({34'd0, a});
        sb_ = (op == 2'd1) ? $signed({{34{b[31]}}, b}) : $signed({34'd0, b});
        p = sa * sb_;
        return (op == 2'd0) ? p[31:0] : p[63:32];
`else
        sa = $signed({34'd0, a});
        sb_ = $signed({34'd0, b});
        p = sa * sb_;
        return p[31:0];
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one line per consumed result.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("result rd=%0d res=0x%08h exp=0x%08h", bus.out_rd, bus.out_result, e.res);
                    check("out_result", bus.out_result, e.res);
                    check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        int waited;
        bit got;
        waited = 0;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.funct3   = {1'($urandom_range(0, 1)), op};
        bus.rs1_val  = a;
        bus.rs2_val  = b;
        bus.rd       = t;
        while (!got && waited < 500) begin
            @(negedge clock);
            if (bus.in_ready) got = 1'b1;
            else waited++;
        end
        if (got) begin
            sb.push_back('{rd: t, res: ref_mul(op, a, b)});
            prev_acc = last_acc;
            last_acc = cyc;
            $display("issue op=%0d a=0x%08h b=0x%08h rd=%0d cycle=%0d", op, a, b, t, cyc);
        end else begin
            check("accept_timeout", {31'd0, got}, 32'd1);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 1000) check("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        forever begin
            @(negedge clock);
            if (bus.out_valid || n >= 200) break;
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        exp_t e;
        logic [31:0] ta [4];
        logic [31:0] tb_ [4];
        logic [1:0]  top [4];

        bus.in_valid = 1'b0;
        bus.funct3 = 3'd0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd = '0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // 5*3 latency and return to ready
        issue(2'd0, 32'd5, 32'd3, 5'd5);
        wait_valid(n);
        check("latency", 32'(n), 32'd33);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("ready_after_done", {31'd0, bus.in_ready}, 32'd1);
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        @(posedge clock);
        #1;

        // Corner operands across all funct3 values, back to back for throughput
        ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'd2;
        ta[1] = 32'h8000_0000; tb_[1] = 32'h8000_0000;
        for (int v = 0; v < 2; v++) begin
            for (int op = 0; op < 4; op++) begin
                issue(2'(op), ta[v], tb_[v], 5'(v * 4 + op + 1));
                if (op > 0) check("throughput", 32'(last_acc - prev_acc), 32'd34);
            end
        end
        wait_idle();

        // Backpressure: result held for 5 cycles
        bus.out_ready = 1'b0;
        issue(2'd0, 32'd123, 32'd456, 5'd9);
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd33);
        e = sb[0];
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_result", bus.out_result, e.res);
            check("bp_out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_busy", {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        issue(2'd0, 32'd11, 32'd13, 5'd10);
        check("bp_reaccept", 32'(sb.size()), 32'd1);
        wait_idle();

        // Flush in RUN cycle 10 with a competing in_valid
        issue(2'd0, 32'd1000, 32'd1000, 5'd11);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.rs1_val = 32'd3;
        bus.rs2_val = 32'd4;
        bus.rd = 5'd12;
        void'(sb.pop_back());
        @(negedge clock);
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("flush_in_ready_next", {31'd0, bus.in_ready}, 32'd1);
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (40) @(posedge clock);
        #1;
        issue(2'd0, 32'd7, 32'd6, 5'd13);
        wait_idle();

        // Reset during DONE
        bus.out_ready = 1'b0;
        issue(2'd0, 32'd77, 32'd3, 5'd14);
        wait_valid(n);
        @(posedge clock);
        #1;
        reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_done_out_result", bus.out_result, 32'd0);
        check("rst_done_out_rd", {27'd0, bus.out_rd}, 32'd0);
        check("rst_done_busy", {31'd0, bus.busy}, 32'd0);
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clock);
        #1;

        // Random ops under random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 30; k++) begin
            top[0] = 2'($urandom_range(0, 3));
            issue(top[0], pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
        end
        wait_idle();
        rand_bp = 1'b0;
        @(posedge clock);
        #2;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
